inst_queue: RTL and testbench

Parametrised fetch-to-decode instruction queue that replaces the single-entry IF/ID pipeline register. It buffers up to DEPTH fetched entries, each holding a pc, an instruction and a predicted next pc. IF pushes with a valid/ready handshake; ID consumes the head entry unless stalled. A flush from the branch-resolution logic discards all buffered entries in one cycle, and an empty queue presents a NOP bubble to decode.

---
 rtl/inst_queue_pkg.sv | 30 +++
 rtl/iq_storage.sv | 32 +++
 rtl/inst_queue.sv | 116 +++++++++++
 tb/tb_inst_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// ---------------------------------------------------------------------------
// inst_queue_pkg : shared types and constants for the fetch-to-decode queue
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package inst_queue_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int IQ_ADDR_W = 32;
  localparam int IQ_INST_W = 32;

  // Level at which id_stall / flush take effect
  localparam logic STALL_ON = 1'b1;
  localparam logic FLUSH_ON = 1'b1;

  typedef struct packed {
    logic [IQ_ADDR_W-1:0] pc;
    logic [IQ_INST_W-1:0] inst;
    logic [IQ_ADDR_W-1:0] prediction;
  } iq_entry_t;

  function automatic int iq_entry_width(input int addr_w, input int inst_w);
    return 2 * addr_w + inst_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iq_storage.sv
// ---------------------------------------------------------------------------
// iq_storage : DEPTH x WIDTH register array, one write port, one async read
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] r_mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue : IF->ID instruction queue with flush and NOP bubble on empty
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int                 ADDR_W     = 32,
  parameter int                 INST_W     = 32,
  parameter int                 DEPTH      = 4,
  parameter logic [INST_W-1:0]  FLUSH_INST = INST_W'(NOP_INST)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     if_valid_i,
  output logic                     if_ready_o,
  input  logic [ADDR_W-1:0]        if_pc_i,
  input  logic [INST_W-1:0]        if_inst_i,
  input  logic [ADDR_W-1:0]        if_prediction_i,
  input  logic                     id_stall_i,
  output logic                     id_valid_o,
  output logic [ADDR_W-1:0]        id_pc_o,
  output logic [INST_W-1:0]        id_inst_o,
  output logic [ADDR_W-1:0]        id_prediction_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int c_PTR_W   = $clog2(DEPTH);
  localparam int c_ENTRY_W = iq_entry_width(ADDR_W, INST_W);

  localparam logic [c_PTR_W:0]   c_DEPTH   = (c_PTR_W+1)'(DEPTH);
  localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W+1)'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] prediction;
  } entry_t;

  logic [c_PTR_W-1:0] r_rptr_q,  r_rptr_d;
  logic [c_PTR_W-1:0] r_wptr_q,  r_wptr_d;
  logic [c_PTR_W:0]   r_count_q, r_count_d;

  logic   w_flush;
  logic   w_ready;
  logic   w_valid;
  logic   w_push;
  logic   w_pop;
  entry_t w_wdata;
  entry_t w_rdata;

  assign w_flush = (flush_i == FLUSH_ON);
  assign w_ready = (r_count_q < c_DEPTH);
  assign w_valid = (r_count_q != '0);
  assign w_push  = if_valid_i & w_ready & ~w_flush;
  assign w_pop   = w_valid & (id_stall_i != STALL_ON) & ~w_flush;

  always_comb begin
    r_rptr_d  = r_rptr_q;
    r_wptr_d  = r_wptr_q;
    r_count_d = r_count_q;
    if (w_flush) begin
      r_rptr_d  = '0;
      r_wptr_d  = '0;
      r_count_d = '0;
    end else begin
      if (w_push) r_wptr_d = r_wptr_q + c_PTR_ONE;
      if (w_pop)  r_rptr_d = r_rptr_q + c_PTR_ONE;
      if (w_push && !w_pop) r_count_d = r_count_q + c_CNT_ONE;
      if (w_pop && !w_push) r_count_d = r_count_q - c_CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rptr_q  <= '0;
      r_wptr_q  <= '0;
      r_count_q <= '0;
    end else begin
      r_rptr_q  <= r_rptr_d;
      r_wptr_q  <= r_wptr_d;
      r_count_q <= r_count_d;
    end
  end

  assign w_wdata.pc         = if_pc_i;
  assign w_wdata.inst       = if_inst_i;
  assign w_wdata.prediction = if_prediction_i;

  iq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_storage (
    .clk_i   (clk_i),
    .we_i    (w_push),
    .waddr_i (r_wptr_q),
    .wdata_i (w_wdata),
    .raddr_i (r_rptr_q),
    .rdata_o (w_rdata)
  );

  // Stale array contents are masked by the bubble whenever the queue is empty
  assign id_valid_o      = w_valid;
  assign id_pc_o         = w_valid ? w_rdata.pc         : '0;
  assign id_inst_o       = w_valid ? w_rdata.inst       : FLUSH_INST;
  assign id_prediction_o = w_valid ? w_rdata.prediction : '0;
  assign if_ready_o      = w_ready;
  assign count_o         = r_count_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_queue : directed vector table plus randomized queue-model checking
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] if_prediction;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_prediction;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_queue #(
    .ADDR_W (32),
    .INST_W (32),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .if_valid_i      (if_valid),
    .if_ready_o      (if_ready),
    .if_pc_i         (if_pc),
    .if_inst_i       (if_inst),
    .if_prediction_i (if_prediction),
    .id_stall_i      (id_stall),
    .id_valid_o      (id_valid),
    .id_pc_o         (id_pc),
    .id_inst_o       (id_inst),
    .id_prediction_o (id_prediction),
    .count_o         (count)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle with the given inputs; returns 1 ns after the edge
  task automatic apply(input logic r, input logic f, input logic v, input logic s,
                       input logic [31:0] pc);
    rst           = r;
    flush         = f;
    if_valid      = v;
    id_stall      = s;
    if_pc         = pc;
    if_inst       = inst_of(pc);
    if_prediction = pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int ecnt, input logic [31:0] epc);
    logic ev;
    ev = (ecnt != 0);
    chk({tag, ".count"}, 32'(count), 32'(ecnt));
    chk({tag, ".id_valid"}, 32'(id_valid), 32'(ev));
    chk({tag, ".if_ready"}, 32'(if_ready), 32'(ecnt < DEPTH));
    chk({tag, ".id_pc"}, id_pc, ev ? epc : 32'h0);
    chk({tag, ".id_inst"}, id_inst, ev ? inst_of(epc) : NOP_INST);
    chk({tag, ".id_pred"}, id_prediction, ev ? epc + 32'd4 : 32'h0);
  endtask

  // Reference model: the queue contents as a list of entries
  iq_entry_t mq[$];

  task automatic model_step(input logic r, input logic f, input logic v, input logic s,
                            input logic [31:0] pc);
    bit push, pop;
    iq_entry_t e;
    push = v && (mq.size() < DEPTH) && !f;
    pop  = (mq.size() > 0) && !s && !f;
    if (r || f) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc = pc;
        e.inst = inst_of(pc);
        e.prediction = pc + 32'd4;
        mq.push_back(e);
      end
    end
  endtask

  typedef struct {
    logic        r;
    logic        f;
    logic        v;
    logic        s;
    logic [31:0] pc;
    int          ecnt;
    logic [31:0] epc;
  } vec_t;

  vec_t tv[26];

  initial begin
    logic r, f, v, s;
    logic [31:0] pc;
    int head;

    tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h000, 0, 32'h000};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h000, 0, 32'h000};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1, 32'h100};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h104, 2, 32'h100};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h108, 3, 32'h100};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h10C, 4, 32'h100};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h110, 4, 32'h100};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h110, 3, 32'h104};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h110, 3, 32'h108};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h114, 3, 32'h10C};
    tv[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 2, 32'h110};
    tv[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 1, 32'h114};
    tv[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 0, 32'h000};
    tv[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h000, 0, 32'h000};
    tv[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h180, 1, 32'h180};
    tv[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h184, 2, 32'h180};
    tv[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h188, 2, 32'h184};
    tv[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h18C, 2, 32'h188};
    tv[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h190, 3, 32'h188};
    tv[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 0, 32'h000};
    tv[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 1, 32'h300};
    tv[21] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h304, 2, 32'h300};
    tv[22] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h308, 0, 32'h000};
    tv[23] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 1, 32'h400};
    tv[24] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h404, 1, 32'h404};
    tv[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 0, 32'h000};

    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_stall = 1'b0;
    if_pc = '0; if_inst = '0; if_prediction = '0;
    #2;

    foreach (tv[i]) begin
      apply(tv[i].r, tv[i].f, tv[i].v, tv[i].s, tv[i].pc);
      chk_state($sformatf("vec%0d", i), tv[i].ecnt, tv[i].epc);
    end

    // Reset mid-operation while full with a push and pop both offered
    for (int i = 0; i < DEPTH; i++) apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h500 + 32'(4 * i));
    chk_state("full", DEPTH, 32'h500);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 32'h600);
    chk_state("rst_full", 0, 32'h0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h604);
    chk_state("after_rst", 1, 32'h604);

    // Randomized traffic against the queue model
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    mq.delete();
    for (int c = 0; c < 10000; c++) begin
      r  = ($urandom_range(199) == 0);
      f  = ($urandom_range(39) == 0);
      v  = ($urandom_range(9) < 7);
      s  = ($urandom_range(9) < 4);
      pc = $urandom & 32'hFFFF_FFFC;
      model_step(r, f, v, s, pc);
      apply(r, f, v, s, pc);
      head = mq.size();
      chk("rnd.count", 32'(count), 32'(head));
      chk("rnd.if_ready", 32'(if_ready), 32'(head < DEPTH));
      chk("rnd.id_valid", 32'(id_valid), 32'(head > 0));
      if (head > 0) begin
        chk("rnd.id_pc", id_pc, mq[0].pc);
        chk("rnd.id_inst", id_inst, mq[0].inst);
        chk("rnd.id_pred", id_prediction, mq[0].prediction);
      end else begin
        chk("rnd.id_pc", id_pc, 32'h0);
        chk("rnd.id_inst", id_inst, NOP_INST);
        chk("rnd.id_pred", id_prediction, 32'h0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
